ipf_fetch_ctrl: RTL
===================

# ipf_fetch_ctrl

Instruction-fetch sequencer for the IPF stage. Owns the fetch PC, issues single-outstanding requests on the SRAM-like instruction port, and handles redirects and flushes, including cancelling in-flight requests. It flags fetch-address exceptions and presents one fetched instruction at a time, with PC+4, miss and exception fields, to the IPF/IF pipeline register. It also generates the front-end stall request fed into that register's stall inputs.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  exception/eret flush; highest priority
- flush_pc  in  32  target on flush
- redirect  in  1  branch/jump redirect (already past delay slot)
- redirect_pc  in  32  target on redirect
- pipe_stall  in  1  downstream cannot accept this cycle
- tlb_miss  in  1  combinational TLB lookup result for inst_addr
- inst_req  out  1  request valid
- inst_addr  out  32  request address (= pc)
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  data returned this cycle
- inst_rdata  in  32  returned instruction
- fetch_valid  out  1  fetch_* outputs hold a valid entry
- fetch_pc_plus4  out  32  PC+4 of presented entry
- fetch_inst  out  32  instruction (0 when exception)
- fetch_exc_type  out  32  0, EXC_ADEL_IF or EXC_TLBL_IF
- fetch_miss  out  1  TLB miss flag of entry
- stall_req  out  1  front end has nothing to deliver

## Operation
- States: REQ, WAIT_DATA, HOLD, CANCEL, EXC_WAIT.
- REQ: inst_req=1 unless pc[1:0]!=0 or tlb_miss.
  - On inst_addr_ok: latch pc, pc<=pc+4, go to WAIT_DATA.
  - On misaligned pc: no request; present entry with exc EXC_ADEL_IF; go to EXC_WAIT.
  - On tlb_miss (aligned pc): no request; present entry with EXC_TLBL_IF and fetch_miss=1; go to EXC_WAIT.
- WAIT_DATA: on inst_data_ok, present entry (inst_rdata, latched pc+4), then go to HOLD.
- HOLD: entry stays presented while pipe_stall=1. On the first cycle with pipe_stall=0 the entry is consumed; go to REQ.
- EXC_WAIT: entry stays presented until consumed, then fetch stops (inst_req=0) until flush.
- Redirect/flush in REQ or HOLD: drop any presented entry, pc<=target, go to REQ.
- Redirect/flush in WAIT_DATA:
  - If inst_data_ok is in the same cycle, drop the data and go to REQ.
  - Otherwise go to CANCEL. CANCEL holds inst_req=0 until inst_data_ok, discards the data, then goes to REQ.
- Priority: flush > redirect > pipe_stall.
- A redirect and a request accept (addr_ok) in the same cycle: the accepted request becomes outstanding, so go to CANCEL; pc<=target.
- Outputs are registered. fetch_valid=1 exactly in the cycles an entry is presented.
- stall_req = ~fetch_valid & ~flush.
- pc+4 arithmetic is 32-bit wrapping: 32'hFFFF_FFFC gives 0.

## Timing
- Reset values:
  - pc=RESET_PC, state=REQ.
  - inst_req=1 in the first cycle after reset release.
  - fetch_valid=0; fetch_pc_plus4, fetch_inst and fetch_exc_type all 0; fetch_miss=0; stall_req=1.
- rst_n low mid-transaction: return to reset state immediately. Any later inst_data_ok for the abandoned request is ignored.
- Latency:
  - addr_ok in cycle t with data_ok in t+1 gives fetch_valid in t+2.
  - The next inst_req rises in the cycle after consumption.
- Redirect in cycle t: fetch_valid=0 from t+1. The new request is issued in t+1, or in the cycle after the stale data_ok if in CANCEL.
- inst_addr is stable while inst_req=1 and addr_ok=0.

## Structure
- Shared package ipf_pkg holds:
  - EXC_ADEL_IF=32'h0000_0004 and EXC_TLBL_IF=32'h0000_0008;
  - the state enum;
  - RESET_PC default.
- No sub-module. Single FSM plus PC register and output register in one file.

## Test plan
- Reset, addr_ok=1 immediately, data_ok next cycle with rdata=32'h2408_0001 → fetch_valid two cycles later with fetch_pc_plus4=32'hBFC0_0004; next inst_addr=32'hBFC0_0004.
- pipe_stall=1 for 3 cycles while entry presented → fetch_valid and fetch_inst stable for 4 cycles; no inst_req until release.
- Redirect to 32'h8000_0100 in WAIT_DATA, stale data_ok arrives 2 cycles later → stale data never presented; next inst_addr=32'h8000_0100.
- flush_pc=32'h8000_0182 → no request; entry with fetch_exc_type=EXC_ADEL_IF, fetch_inst=0; inst_req=0 until next flush.
- tlb_miss=1 at 32'h0040_0000 → fetch_miss=1, exc=EXC_TLBL_IF, no inst_req.
- flush and redirect asserted together → pc=flush_pc; rst_n low during WAIT_DATA → pc=RESET_PC, fetch_valid=0.

Source files
------------

// File: rtl/ipf_pkg.sv
// ipf_pkg: shared constants and types for the IPF fetch stage.
// Exception codes, reset PC and fetch sequencer states.
package ipf_pkg;

    localparam logic [31:0] EXC_ADEL_IF  = 32'h0000_0004;
    localparam logic [31:0] EXC_TLBL_IF  = 32'h0000_0008;
    localparam logic [31:0] IPF_RESET_PC = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT_DATA,
        S_HOLD,
        S_CANCEL,
        S_EXC_WAIT
    } ipf_state_e;

endpackage

// File: rtl/ipf_fetch_ctrl.sv
// ipf_fetch_ctrl: single-outstanding instruction fetch sequencer.
// Owns the fetch PC, cancels stale requests, presents one entry at a time.
module ipf_fetch_ctrl
    import ipf_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IPF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        pipe_stall,
    input  logic        tlb_miss,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc_plus4,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_exc_type,
    output logic        fetch_miss,
    output logic        stall_req
);

    ipf_state_e  state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] req_pc4, req_pc4_d;
    logic        valid_d, miss_d;
    logic [31:0] pc4_d, inst_d, exc_d;
    logic [31:0] pc_plus4, tgt;
    logic        misalign, jump;

    assign pc_plus4  = pc + 32'd4;
    assign misalign  = pc[1:0] != 2'b00;
    assign jump      = flush | redirect;
    assign tgt       = flush ? flush_pc : redirect_pc;
    assign inst_req  = (state == S_REQ) & ~misalign & ~tlb_miss;
    assign inst_addr = pc;
    assign stall_req = ~fetch_valid & ~flush;

    // Next state, next PC and next presented entry.
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        req_pc4_d = req_pc4;
        valid_d   = fetch_valid;
        pc4_d     = fetch_pc_plus4;
        inst_d    = fetch_inst;
        exc_d     = fetch_exc_type;
        miss_d    = fetch_miss;
        unique case (state)
            S_REQ: begin
                if (jump) begin
                    // An accepted request still returns data later.
                    valid_d = 1'b0;
                    pc_d    = tgt;
                    state_d = (inst_req & inst_addr_ok) ? S_CANCEL : S_REQ;
                end else if (misalign) begin
                    valid_d = 1'b1;
                    pc4_d   = pc_plus4;
                    inst_d  = '0;
                    exc_d   = EXC_ADEL_IF;
                    miss_d  = 1'b0;
                    state_d = S_EXC_WAIT;
                end else if (tlb_miss) begin
                    valid_d = 1'b1;
                    pc4_d   = pc_plus4;
                    inst_d  = '0;
                    exc_d   = EXC_TLBL_IF;
                    miss_d  = 1'b1;
                    state_d = S_EXC_WAIT;
                end else if (inst_addr_ok) begin
                    req_pc4_d = pc_plus4;
                    pc_d      = pc_plus4;
                    state_d   = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (jump) begin
                    pc_d    = tgt;
                    state_d = inst_data_ok ? S_REQ : S_CANCEL;
                end else if (inst_data_ok) begin
                    valid_d = 1'b1;
                    pc4_d   = req_pc4;
                    inst_d  = inst_rdata;
                    exc_d   = '0;
                    miss_d  = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (jump) begin
                    valid_d = 1'b0;
                    pc_d    = tgt;
                    state_d = S_REQ;
                end else if (!pipe_stall) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_CANCEL: begin
                if (jump) begin
                    pc_d = tgt;
                end
                if (inst_data_ok) begin
                    state_d = S_REQ;
                end
            end
            S_EXC_WAIT: begin
                // Only a flush restarts fetch after an exception.
                if (flush) begin
                    valid_d = 1'b0;
                    pc_d    = flush_pc;
                    state_d = S_REQ;
                end else if (!pipe_stall) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // State, PC and registered fetch outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            req_pc4        <= '0;
            fetch_valid    <= 1'b0;
            fetch_pc_plus4 <= '0;
            fetch_inst     <= '0;
            fetch_exc_type <= '0;
            fetch_miss     <= 1'b0;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            req_pc4        <= req_pc4_d;
            fetch_valid    <= valid_d;
            fetch_pc_plus4 <= pc4_d;
            fetch_inst     <= inst_d;
            fetch_exc_type <= exc_d;
            fetch_miss     <= miss_d;
        end
    end

endmodule
